// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo up/down counter with wrap or saturate behaviour.
//
// Counts over 0..MAX. With en=1, up=1 and default parameters the output
// sequence is 0,1,...,128,0,...
//
// Parameters:
//   WIDTH    - counter width in bits
//   MAX      - terminal value, inclusive (1 <= MAX <= 2^WIDTH-1)
//   SATURATE - 0: wrap at the boundaries, 1: hold at the boundaries
//   WCNT_W   - width of the saturating wrap/saturate event counter
//
// Ports:
//   clk      - clock, all state updates on posedge
//   rst      - synchronous active-high reset, dominates all other inputs
//   en       - count enable
//   up       - direction (1 = increment, 0 = decrement), used only when en=1
//   load     - synchronous load strobe, wins over en
//   load_val - load value, clamped to MAX
//   Q        - current count (registered)
//   at_max   - Q == MAX (combinational)
//   at_zero  - Q == 0 (combinational)
//   wrap     - one-cycle pulse on a wrap transition (SATURATE=0)
//   sat      - one-cycle pulse on a blocked step at a boundary (SATURATE=1)
//   wrap_cnt - number of wrap/sat events since reset, saturates at all-ones
module mod_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 128,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned WCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  Q,
  output logic              at_max,
  output logic              at_zero,
  output logic              wrap,
  output logic              sat,
  output logic [WCNT_W-1:0] wrap_cnt
);

  // Reject illegal terminal values at elaboration time.
  if (WIDTH < 1 || WCNT_W < 1) begin : gen_bad_width
    $error("mod_counter: WIDTH and WCNT_W must be at least 1");
  end
  if (MAX < 1 || (WIDTH < 32 && MAX > ((32'd1 << WIDTH) - 32'd1))) begin : gen_bad_max
    $error("mod_counter: MAX must satisfy 1 <= MAX <= 2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0]  MaxVal  = WIDTH'(MAX);
  localparam logic [WCNT_W-1:0] CntFull = {WCNT_W{1'b1}};

  logic [WIDTH-1:0]  q_q, q_d;
  logic              wrap_q, wrap_d;
  logic              sat_q, sat_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (load) begin
      q_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (up) begin
        // Boundary test happens before the increment, so Q+1 never overflows
        // into the result when MAX is all-ones.
        if (q_q == MaxVal) begin
          if (SATURATE) begin
            sat_d = 1'b1;
          end else begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          if (SATURATE) begin
            sat_d = 1'b1;
          end else begin
            q_d    = MaxVal;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if ((wrap_d || sat_d) && (wcnt_q != CntFull)) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
      wcnt_q <= '0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign Q        = q_q;
  assign at_max   = (q_q == MaxVal);
  assign at_zero  = (q_q == '0);
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign wrap_cnt = wcnt_q;

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter, the next generation of the free-running 8-bit wrap-at-128 counter. It adds:
- configurable width and terminal value;
- enable, direction and synchronous load;
- wrap or saturate mode;
- registered wrap/saturate event pulses and a saturating wrap counter.

It is used wherever the design needs a bounded cycle or event counter. With `en=1`, `up=1` and the defaults, it reproduces the legacy sequence 0,1,…,128,0,….

## Interface
- `WIDTH`, 8, counter width in bits.
- `MAX`, 128, terminal value, inclusive. Count range is 0..MAX. Legal range 1 ≤ MAX ≤ 2^WIDTH−1; elaboration fails otherwise.
- `SATURATE`, 0, boundary mode. 0 = wrap, 1 = hold at boundary.
- `WCNT_W`, 16, width of the wrap/saturate event counter.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset. Synchronous, active-high; dominates every other input.
- `en`  in  1  count enable.
- `up`  in  1  direction. 1 = increment, 0 = decrement; sampled only when `en=1`.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  load value.
- `Q`  out  WIDTH  current count, registered.
- `at_max`  out  1  combinational, `Q == MAX`.
- `at_zero`  out  1  combinational, `Q == 0`.
- `wrap`  out  1  registered one-cycle pulse on a wrap transition (SATURATE=0 only).
- `sat`  out  1  registered one-cycle pulse on a blocked step at a boundary (SATURATE=1 only).
- `wrap_cnt`  out  WCNT_W  number of `wrap`/`sat` events since reset; saturates at all-ones.

## Operation
Per-cycle update, in priority order:
1. **`rst`**
   - `Q`, `wrap`, `sat` and `wrap_cnt` go to 0.
   - Reset values: `Q=0`, `at_zero=1`, `at_max=0`, `wrap=0`, `sat=0`, `wrap_cnt=0`.
2. **`load`** (`en` ignored)
   - `Q <= min(load_val, MAX)`; out-of-range values clamp to MAX.
   - `wrap` and `sat` are 0 next cycle; `wrap_cnt` holds.
3. **`en & up`**
   - `Q < MAX`: `Q <= Q+1`.
   - `Q == MAX`, SATURATE=0: `Q <= 0`, `wrap <= 1`.
   - `Q == MAX`, SATURATE=1: `Q` holds, `sat <= 1`.
4. **`en & !up`**
   - `Q > 0`: `Q <= Q−1`.
   - `Q == 0`, SATURATE=0: `Q <= MAX`, `wrap <= 1`.
   - `Q == 0`, SATURATE=1: `Q` holds, `sat <= 1`.
5. **Otherwise:** `Q` holds; `wrap` and `sat` are 0.

Arithmetic and event rules:
- All arithmetic is WIDTH-bit unsigned. `Q` never leaves 0..MAX after reset. An intermediate Q+1 at MAX = 2^WIDTH−1 must not affect the result.
- `wrap_cnt` increments by 1 in the same update that sets `wrap` or `sat`. At all-ones it holds.
- `wrap` and `sat` are never both 1. Each is 1 for exactly one cycle per event. Back-to-back events (e.g. MAX=1 counting up: 0,1,0,1) assert the pulse on every qualifying cycle.

## Timing
- **Latency.** One cycle from the sampled input to the new `Q`. `wrap`/`sat` assert in the same cycle the new `Q` is visible. For an up-wrap, `wrap=1` coincides with `Q=0`.
- **Combinational flags.** `at_max` and `at_zero` follow `Q` combinationally, with no added latency.
- **Simultaneous inputs.**
  - `rst` with `load`/`en`: reset wins.
  - `load` with `en`: load wins and no event is generated, even when `Q` is at a boundary.
- **Reset mid-operation.** A reset asserted in the cycle after a wrap clears `wrap` and `wrap_cnt` on that edge. Reset applied while `wrap=1` yields `wrap=0` next cycle.
- **Direction changes.** `up` may change every cycle and takes effect on the next edge with no penalty.

## Test plan
- **Defaults, free-run.** `rst` for 2 cycles, then `en=1`, `up=1` for 260 cycles → `Q` runs 0..128 then 0. `wrap=1` exactly when `Q` returns to 0, on cycles 130 and 259 after reset release. `wrap_cnt=2`.
- **Down-wrap.** MAX=5; `load` with `load_val=0`, then `en=1`, `up=0` → `Q` = 5,4,3,2,1,0,5. `wrap` pulses with each return to 5.
- **Saturate.** SATURATE=1, MAX=10; load 9, then up for 3 cycles → `Q` = 10,10,10. `sat` = 0,1,1 on those cycles; `wrap` stays 0; `wrap_cnt=2`.
- **Load clamp and priority.** MAX=128; `load=1`, `load_val=200`, `en=1` → `Q=128`, no event. Next cycle `rst=1`, `load=1` → `Q=0`, `at_zero=1`, `wrap_cnt=0`.
- **Event-counter saturation.** WCNT_W=2, MAX=1, up continuously → `wrap_cnt` = 1,2,3,3,3…; `wrap` keeps pulsing every second cycle.
- **Full-range wrap.** WIDTH=4, MAX=15, up from 14 → `Q` = 15, 0, 1 with `wrap` on the 0. No X, no overflow artifacts.
